// File: rtl/eeg_oram_acc_pkg.sv
// eeg_oram_pkg: shared types and helpers for the ORAM accumulation lane.
//   oram_acc_st_e : accumulator FSM state encoding
//   sat_max_f     : largest value of a signed word of width dw
//   sat_min_f     : smallest value of a signed word of width dw
package eeg_oram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2,
    CLR  = 2'd3
  } oram_acc_st_e;

  // Positive clamp value for a dw-bit two's complement word.
  function automatic logic signed [63:0] sat_max_f(input int dw);
    sat_max_f = (64'sd1 <<< (dw - 32'sd1)) - 64'sd1;
  endfunction

  // Negative clamp value for a dw-bit two's complement word.
  function automatic logic signed [63:0] sat_min_f(input int dw);
    sat_min_f = 64'sd0 - (64'sd1 <<< (dw - 32'sd1));
  endfunction

endpackage

// File: rtl/eeg_oram_acc_if.sv
// eeg_oram_acc_if: bundles every handshake stream of one accumulation lane.
//   PSUM_*      : tagged partial sums in
//   CLR_*       : clear-lane request and completion pulse
//   SAT_FLG     : sticky saturation indicator
//   ORAM_DIN_*  : ORAM write port
//   ORAM_ADD_*  : ORAM read-address port
//   ORAM_DAT_*  : ORAM read-data port
//   OUT_*       : final-pass result stream
// Modports: slave = accumulator side, master = environment (producer/RAM/sink).
interface eeg_oram_acc_if #(
  parameter int ORAM_ADD_MW = 8,
  parameter int ORAM_DAT_DW = 8,
  parameter int PSUM_DW     = 8
);

  logic                   PSUM_VLD;
  logic                   PSUM_RDY;
  logic                   PSUM_FST;
  logic                   PSUM_LST;
  logic [ORAM_ADD_MW-1:0] PSUM_ADD;
  logic [PSUM_DW-1:0]     PSUM_DAT;

  logic                   CLR_VLD;
  logic                   CLR_RDY;
  logic                   CLR_DONE;
  logic                   SAT_FLG;

  logic                   ORAM_DIN_VLD;
  logic                   ORAM_DIN_RDY;
  logic [ORAM_ADD_MW-1:0] ORAM_DIN_ADD;
  logic [ORAM_DAT_DW-1:0] ORAM_DIN_DAT;

  logic                   ORAM_ADD_VLD;
  logic                   ORAM_ADD_LST;
  logic                   ORAM_ADD_RDY;
  logic [ORAM_ADD_MW-1:0] ORAM_ADD_ADD;

  logic                   ORAM_DAT_VLD;
  logic                   ORAM_DAT_LST;
  logic                   ORAM_DAT_RDY;
  logic [ORAM_DAT_DW-1:0] ORAM_DAT_DAT;

  logic                   OUT_VLD;
  logic                   OUT_RDY;
  logic [ORAM_ADD_MW-1:0] OUT_ADD;
  logic [ORAM_DAT_DW-1:0] OUT_DAT;

  modport slave (
    input  PSUM_VLD, PSUM_FST, PSUM_LST, PSUM_ADD, PSUM_DAT,
    output PSUM_RDY,
    input  CLR_VLD,
    output CLR_RDY, CLR_DONE, SAT_FLG,
    output ORAM_DIN_VLD, ORAM_DIN_ADD, ORAM_DIN_DAT,
    input  ORAM_DIN_RDY,
    output ORAM_ADD_VLD, ORAM_ADD_LST, ORAM_ADD_ADD,
    input  ORAM_ADD_RDY,
    input  ORAM_DAT_VLD, ORAM_DAT_LST, ORAM_DAT_DAT,
    output ORAM_DAT_RDY,
    output OUT_VLD, OUT_ADD, OUT_DAT,
    input  OUT_RDY
  );

  modport master (
    output PSUM_VLD, PSUM_FST, PSUM_LST, PSUM_ADD, PSUM_DAT,
    input  PSUM_RDY,
    output CLR_VLD,
    input  CLR_RDY, CLR_DONE, SAT_FLG,
    input  ORAM_DIN_VLD, ORAM_DIN_ADD, ORAM_DIN_DAT,
    output ORAM_DIN_RDY,
    input  ORAM_ADD_VLD, ORAM_ADD_LST, ORAM_ADD_ADD,
    output ORAM_ADD_RDY,
    output ORAM_DAT_VLD, ORAM_DAT_LST, ORAM_DAT_DAT,
    input  ORAM_DAT_RDY,
    input  OUT_VLD, OUT_ADD, OUT_DAT,
    output OUT_RDY
  );

endinterface

// File: rtl/eeg_oram_acc_sat_add.sv
// eeg_sat_add: combinational signed saturating adder.
//   a_i, b_i : DW-bit two's complement operands
//   sum_o    : a_i + b_i clamped to the DW-bit signed range
//   ovf_o    : high when the clamp was applied
module eeg_sat_add
  import eeg_oram_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] sum_o,
  output logic                 ovf_o
);

  localparam logic signed [DW-1:0] SAT_MAX = DW'(sat_max_f(DW));
  localparam logic signed [DW-1:0] SAT_MIN = DW'(sat_min_f(DW));

  logic [DW:0] wide_s;

  // One guard bit: overflow shows as disagreement between the top two bits.
  always_comb begin
    wide_s = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};
    ovf_o  = wide_s[DW] ^ wide_s[DW-1];
    if (!ovf_o) begin
      sum_o = wide_s[DW-1:0];
    end else if (wide_s[DW]) begin
      sum_o = SAT_MIN;
    end else begin
      sum_o = SAT_MAX;
    end
  end

endmodule

// File: rtl/eeg_oram_acc.sv
// eeg_oram_acc: read-modify-write accumulation engine for one ORAM lane.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : all lane streams (psum in, clear, ORAM write/read ports, result out)
// First-pass psums overwrite the addressed word; later passes read it, add with
// saturation and write back. Last-pass results are forwarded on OUT_*. A clear
// sweep writes zero to every address of the lane.
module eeg_oram_acc
  import eeg_oram_pkg::*;
#(
  parameter int ORAM_ADD_MW = 8,
  parameter int ORAM_DAT_DW = 8,
  parameter int PSUM_DW     = 8
) (
  input logic           clk,
  input logic           rst_n,
  eeg_oram_acc_if.slave bus
);

  localparam logic [ORAM_ADD_MW-1:0] CNT_LAST = {ORAM_ADD_MW{1'b1}};

  oram_acc_st_e state_q, state_d;

  // S1: accumulate request waiting for its read data
  logic [ORAM_ADD_MW-1:0] s1_add_q, s1_add_d;
  logic [PSUM_DW-1:0]     s1_dat_q, s1_dat_d;
  logic                   s1_lst_q, s1_lst_d;

  // Write-back held while the write port stalls (read data is gone by then)
  logic                   hold_q, hold_d;
  logic [ORAM_DAT_DW-1:0] hold_sum_q, hold_sum_d;

  logic                   out_vld_q, out_vld_d;
  logic [ORAM_ADD_MW-1:0] out_add_q, out_add_d;
  logic [ORAM_DAT_DW-1:0] out_dat_q, out_dat_d;

  logic [ORAM_ADD_MW-1:0] cnt_q, cnt_d;
  logic                   sat_flg_q, sat_flg_d;

  logic signed [ORAM_DAT_DW-1:0] psum_sext_s;
  logic signed [ORAM_DAT_DW-1:0] s1_sext_s;
  logic signed [ORAM_DAT_DW-1:0] sum_s;
  logic                          sum_ovf_s;
  logic [ORAM_DAT_DW-1:0]        wb_dat_s;

  logic                   psum_rdy_s;
  logic                   clr_rdy_s;
  logic                   clr_done_s;
  logic                   din_vld_s;
  logic [ORAM_ADD_MW-1:0] din_add_s;
  logic [ORAM_DAT_DW-1:0] din_dat_s;
  logic                   add_vld_s;
  logic                   add_lst_s;
  logic [ORAM_ADD_MW-1:0] add_add_s;

  // Read-data LST only echoes the request tag already held in S1.
  logic unused_dat_lst_s;
  assign unused_dat_lst_s = bus.ORAM_DAT_LST;

  assign psum_sext_s = ORAM_DAT_DW'($signed(bus.PSUM_DAT));
  assign s1_sext_s   = ORAM_DAT_DW'($signed(s1_dat_q));

  eeg_sat_add #(
    .DW (ORAM_DAT_DW)
  ) u_sat_add (
    .a_i   (bus.ORAM_DAT_DAT),
    .b_i   (s1_sext_s),
    .sum_o (sum_s),
    .ovf_o (sum_ovf_s)
  );

  // Once stalled, the held sum replaces the (no longer valid) adder result.
  assign wb_dat_s = hold_q ? hold_sum_q : sum_s;

  // Next-state, handshake and ORAM port control.
  always_comb begin
    state_d    = state_q;
    s1_add_d   = s1_add_q;
    s1_dat_d   = s1_dat_q;
    s1_lst_d   = s1_lst_q;
    hold_d     = hold_q;
    hold_sum_d = hold_sum_q;
    out_add_d  = out_add_q;
    out_dat_d  = out_dat_q;
    cnt_d      = cnt_q;
    sat_flg_d  = sat_flg_q;
    psum_rdy_s = 1'b0;
    clr_rdy_s  = 1'b0;
    clr_done_s = 1'b0;
    din_vld_s  = 1'b0;
    din_add_s  = '0;
    din_dat_s  = '0;
    add_vld_s  = 1'b0;
    add_lst_s  = 1'b0;
    add_add_s  = '0;

    case (state_q)
      IDLE: begin
        clr_rdy_s = 1'b1;
        if (bus.CLR_VLD) begin
          // Clear wins; psum valids are masked so the RAM sees no stray request.
          state_d   = CLR;
          cnt_d     = '0;
          sat_flg_d = 1'b0;
        end else if (bus.PSUM_FST) begin
          psum_rdy_s = bus.ORAM_DIN_RDY;
          din_vld_s  = bus.PSUM_VLD;
          din_add_s  = bus.PSUM_ADD;
          din_dat_s  = psum_sext_s;
          if (bus.PSUM_VLD && bus.ORAM_DIN_RDY && bus.PSUM_LST) begin
            out_add_d = bus.PSUM_ADD;
            out_dat_d = psum_sext_s;
            state_d   = OUT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          psum_rdy_s = bus.ORAM_ADD_RDY;
          add_vld_s  = bus.PSUM_VLD;
          add_add_s  = bus.PSUM_ADD;
          add_lst_s  = bus.PSUM_LST;
          if (bus.PSUM_VLD && bus.ORAM_ADD_RDY) begin
            s1_add_d = bus.PSUM_ADD;
            s1_dat_d = bus.PSUM_DAT;
            s1_lst_d = bus.PSUM_LST;
            hold_d   = 1'b0;
            state_d  = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      WAIT: begin
        if (hold_q || bus.ORAM_DAT_VLD) begin
          din_vld_s = 1'b1;
          din_add_s = s1_add_q;
          din_dat_s = wb_dat_s;
          // Overflow is judged once, when the read data actually arrives.
          if (!hold_q && sum_ovf_s) begin
            sat_flg_d = 1'b1;
          end else begin
            sat_flg_d = sat_flg_q;
          end
          if (bus.ORAM_DIN_RDY) begin
            hold_d = 1'b0;
            if (s1_lst_q) begin
              out_add_d = s1_add_q;
              out_dat_d = wb_dat_s;
              state_d   = OUT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            hold_d     = 1'b1;
            hold_sum_d = wb_dat_s;
            state_d    = WAIT;
          end
        end else begin
          state_d = WAIT;
        end
      end

      OUT: begin
        if (bus.OUT_RDY) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end

      CLR: begin
        din_vld_s = 1'b1;
        din_add_s = cnt_q;
        din_dat_s = '0;
        if (bus.ORAM_DIN_RDY) begin
          if (cnt_q == CNT_LAST) begin
            clr_done_s = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + ORAM_ADD_MW'(1'b1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    out_vld_d = (state_d == OUT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s1_add_q   <= '0;
      s1_dat_q   <= '0;
      s1_lst_q   <= 1'b0;
      hold_q     <= 1'b0;
      hold_sum_q <= '0;
      out_vld_q  <= 1'b0;
      out_add_q  <= '0;
      out_dat_q  <= '0;
      cnt_q      <= '0;
      sat_flg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_add_q   <= s1_add_d;
      s1_dat_q   <= s1_dat_d;
      s1_lst_q   <= s1_lst_d;
      hold_q     <= hold_d;
      hold_sum_q <= hold_sum_d;
      out_vld_q  <= out_vld_d;
      out_add_q  <= out_add_d;
      out_dat_q  <= out_dat_d;
      cnt_q      <= cnt_d;
      sat_flg_q  <= sat_flg_d;
    end
  end

  assign bus.PSUM_RDY     = psum_rdy_s;
  assign bus.CLR_RDY      = clr_rdy_s;
  assign bus.CLR_DONE     = clr_done_s;
  assign bus.SAT_FLG      = sat_flg_q;
  assign bus.ORAM_DIN_VLD = din_vld_s;
  assign bus.ORAM_DIN_ADD = din_add_s;
  assign bus.ORAM_DIN_DAT = din_dat_s;
  assign bus.ORAM_ADD_VLD = add_vld_s;
  assign bus.ORAM_ADD_LST = add_lst_s;
  assign bus.ORAM_ADD_ADD = add_add_s;
  assign bus.ORAM_DAT_RDY = 1'b1;
  assign bus.OUT_VLD      = out_vld_q;
  assign bus.OUT_ADD      = out_add_q;
  assign bus.OUT_DAT      = out_dat_q;

endmodule
